// File: rtl/cr_isf_ib_tlv_monitor_if.sv
// AXI4-stream bundle carrying TLVs into the engine ingress.
// The monitor modport is fully passive: it observes tready and never drives it.
interface cr_isf_ib_tlv_monitor_if;
    logic        ib_tvalid;
    logic        ib_tready;
    logic [63:0] ib_tdata;
    logic [7:0]  ib_tstrb;
    logic [1:0]  ib_tuser;

    modport master (
        output ib_tvalid,
        output ib_tdata,
        output ib_tstrb,
        output ib_tuser,
        input  ib_tready
    );

    modport slave (
        input  ib_tvalid,
        input  ib_tdata,
        input  ib_tstrb,
        input  ib_tuser,
        output ib_tready
    );

    modport monitor (
        input ib_tvalid,
        input ib_tready,
        input ib_tdata,
        input ib_tstrb,
        input ib_tuser
    );
endinterface

// File: rtl/cr_isf_ib_tlv_monitor.sv
// Inbound TLV monitor: tracks command boundaries, counts data frames/bytes,
// raises stall/starve stat events and flags TLV sequencing errors.
module cr_isf_ib_tlv_monitor #(
    parameter logic [7:0]  RQE_TYPE      = 8'h00,
    parameter logic [7:0]  CQE_TYPE      = 8'h09,
    parameter logic [7:0]  DATA_TYPE     = 8'h05,
    parameter logic [7:0]  DATA_UNK_TYPE = 8'h0B,
    parameter int unsigned FB_W          = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    cr_isf_ib_tlv_monitor_if.monitor         i_ib,
    input  logic                             i_err_clr,
    output logic                             o_cmd_active,
    output logic                             o_rqe_entry,
    output logic                             o_cqe_exit,
    output logic                             o_ib_frame_cnt_stb,
    output logic                             o_ib_bytes_cnt_stb,
    output logic [3:0]                       o_ib_bytes_cnt_amt,
    output logic                             o_frame_done,
    output logic [FB_W-1:0]                  o_frame_bytes,
    output logic                             o_ib_stall,
    output logic                             o_ib_starve,
    output logic                             o_proto_err,
    output logic [1:0]                       o_proto_err_code
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StInData,
        StInOther,
        StInCqe,
        StSkip
    } state_e;

    state_e          r_state;
    state_e          w_state_d;

    logic            r_cmd_active;
    logic            r_rqe_entry;
    logic            r_cqe_exit;
    logic            r_frame_stb;
    logic            r_bytes_stb;
    logic [3:0]      r_bytes_amt;
    logic            r_frame_done;
    logic [FB_W-1:0] r_frame_bytes;
    logic [FB_W-1:0] r_acc;
    logic            r_stall;
    logic            r_starve;
    logic            r_proto_err;
    logic [1:0]      r_err_code;

    logic            w_cmd_active_d;
    logic            w_rqe_d;
    logic            w_cqe_d;
    logic            w_fstb_d;
    logic            w_bstb_d;
    logic [3:0]      w_amt_d;
    logic            w_fdone_d;
    logic [FB_W-1:0] w_fb_d;
    logic [FB_W-1:0] w_acc_d;
    logic            w_err;
    logic [1:0]      w_code_new;
    logic [1:0]      w_code_d;
    logic            w_parse;

    logic            w_beat;
    logic            w_sot;
    logic            w_eot;
    logic [7:0]      w_type;
    logic [3:0]      w_amt;
    logic [FB_W:0]   w_sum;
    logic [FB_W-1:0] w_acc_inc;
    logic            w_unused_tdata;

    assign w_beat         = i_ib.ib_tvalid & i_ib.ib_tready;
    assign w_sot          = i_ib.ib_tuser[0];
    assign w_eot          = i_ib.ib_tuser[1];
    assign w_type         = i_ib.ib_tdata[7:0];
    assign w_unused_tdata = ^i_ib.ib_tdata[63:8];

    always_comb begin
        w_amt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_amt = w_amt + {3'b000, i_ib.ib_tstrb[i]};
        end
    end

    // One extra bit catches the carry so the accumulator can saturate.
    assign w_sum     = {1'b0, r_acc} + {{(FB_W - 3){1'b0}}, w_amt};
    assign w_acc_inc = w_sum[FB_W] ? {FB_W{1'b1}} : w_sum[FB_W-1:0];

    always_comb begin
        w_state_d      = r_state;
        w_cmd_active_d = r_cmd_active;
        w_rqe_d        = 1'b0;
        w_cqe_d        = 1'b0;
        w_fstb_d       = 1'b0;
        w_bstb_d       = 1'b0;
        w_amt_d        = 4'd0;
        w_fdone_d      = 1'b0;
        w_fb_d         = r_frame_bytes;
        w_acc_d        = r_acc;
        w_err          = 1'b0;
        w_code_new     = 2'd0;
        w_parse        = 1'b0;

        if (w_beat) begin
            unique case (r_state)
                StIdle: begin
                    if (w_sot) begin
                        if (w_type == RQE_TYPE) begin
                            w_rqe_d        = 1'b1;
                            w_cmd_active_d = 1'b1;
                            w_state_d      = w_eot ? StCmd : StInOther;
                        end else begin
                            w_err      = 1'b1;
                            w_code_new = 2'd2;
                            w_state_d  = w_eot ? StIdle : StSkip;
                        end
                    end
                end
                StCmd: w_parse = w_sot;
                StInData: begin
                    if (w_sot) begin
                        w_err      = 1'b1;
                        w_code_new = 2'd1;
                        w_parse    = 1'b1;
                    end else begin
                        w_bstb_d = 1'b1;
                        w_amt_d  = w_amt;
                        w_acc_d  = w_acc_inc;
                        if (w_eot) begin
                            w_fdone_d = 1'b1;
                            w_fb_d    = w_acc_inc;
                            w_state_d = StCmd;
                        end
                    end
                end
                StInOther: begin
                    if (w_sot) begin
                        w_err      = 1'b1;
                        w_code_new = 2'd1;
                        w_parse    = 1'b1;
                    end else if (w_eot) begin
                        w_state_d = StCmd;
                    end
                end
                StInCqe: begin
                    if (w_sot) begin
                        w_err      = 1'b1;
                        w_code_new = 2'd1;
                        w_parse    = 1'b1;
                    end else if (w_eot) begin
                        w_cqe_d        = 1'b1;
                        w_cmd_active_d = 1'b0;
                        w_state_d      = StIdle;
                    end
                end
                StSkip: begin
                    if (w_eot) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase

            // A SOT inside a command, including one that abandons an open TLV.
            if (w_parse) begin
                if ((w_type == DATA_TYPE) || (w_type == DATA_UNK_TYPE)) begin
                    w_fstb_d = 1'b1;
                    w_acc_d  = '0;
                    if (w_eot) begin
                        w_fdone_d = 1'b1;
                        w_fb_d    = '0;
                        w_state_d = StCmd;
                    end else begin
                        w_state_d = StInData;
                    end
                end else if (w_type == CQE_TYPE) begin
                    if (w_eot) begin
                        w_cqe_d        = 1'b1;
                        w_cmd_active_d = 1'b0;
                        w_state_d      = StIdle;
                    end else begin
                        w_state_d = StInCqe;
                    end
                end else if (w_type == RQE_TYPE) begin
                    if (!w_err) begin
                        w_err      = 1'b1;
                        w_code_new = 2'd3;
                    end
                    w_rqe_d        = 1'b1;
                    w_cmd_active_d = 1'b1;
                    w_state_d      = w_eot ? StCmd : StInOther;
                end else begin
                    w_state_d = w_eot ? StCmd : StInOther;
                end
            end
        end
    end

    // First error sticks; a clear in the same cycle lets the new code in.
    always_comb begin
        w_code_d = r_err_code;
        if (w_err) begin
            if ((r_err_code == 2'd0) || i_err_clr) begin
                w_code_d = w_code_new;
            end
        end else if (i_err_clr) begin
            w_code_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cmd_active  <= 1'b0;
            r_rqe_entry   <= 1'b0;
            r_cqe_exit    <= 1'b0;
            r_frame_stb   <= 1'b0;
            r_bytes_stb   <= 1'b0;
            r_bytes_amt   <= 4'd0;
            r_frame_done  <= 1'b0;
            r_frame_bytes <= '0;
            r_acc         <= '0;
            r_stall       <= 1'b0;
            r_starve      <= 1'b0;
            r_proto_err   <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_state       <= w_state_d;
            r_cmd_active  <= w_cmd_active_d;
            r_rqe_entry   <= w_rqe_d;
            r_cqe_exit    <= w_cqe_d;
            r_frame_stb   <= w_fstb_d;
            r_bytes_stb   <= w_bstb_d;
            r_bytes_amt   <= w_amt_d;
            r_frame_done  <= w_fdone_d;
            r_frame_bytes <= w_fb_d;
            r_acc         <= w_acc_d;
            r_stall       <= i_ib.ib_tvalid & ~i_ib.ib_tready;
            r_starve      <= ~i_ib.ib_tvalid & r_cmd_active;
            r_proto_err   <= w_err;
            r_err_code    <= w_code_d;
        end
    end

    assign o_cmd_active       = r_cmd_active;
    assign o_rqe_entry        = r_rqe_entry;
    assign o_cqe_exit         = r_cqe_exit;
    assign o_ib_frame_cnt_stb = r_frame_stb;
    assign o_ib_bytes_cnt_stb = r_bytes_stb;
    assign o_ib_bytes_cnt_amt = r_bytes_amt;
    assign o_frame_done       = r_frame_done;
    assign o_frame_bytes      = r_frame_bytes;
    assign o_ib_stall         = r_stall;
    assign o_ib_starve        = r_starve;
    assign o_proto_err        = r_proto_err;
    assign o_proto_err_code   = r_err_code;

endmodule

// File: doc/cr_isf_ib_tlv_monitor.md
Name: cr_isf_ib_tlv_monitor

Overview:
- Inbound-side support monitor: the receive-end counterpart of the outbound TLV monitor.
- Passively snoops the AXI4-stream carrying TLVs into the engine ingress. It does not modify the stream and does not drive tready.
- Tracks command boundaries (RQE entry through CQE exit), counts data frames and data bytes, and raises stall/starve stat events.
- Flags TLV sequencing protocol errors so the ingress can report malformed commands.

Parameters:
- RQE_TYPE, 8'h00, tlv_type encoding of a request entry TLV
- CQE_TYPE, 8'h09, tlv_type encoding of a completion TLV
- DATA_TYPE, 8'h05, tlv_type encoding of a data TLV
- DATA_UNK_TYPE, 8'h0B, tlv_type encoding of an unknown-format data TLV
- FB_W, 24, width of the per-frame byte accumulator

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ib_tvalid  in  1  snooped stream valid
- ib_tready  in  1  snooped stream ready
- ib_tdata  in  64  snooped data; tlv_type = ib_tdata[7:0] on the SOT beat
- ib_tstrb  in  8  byte strobes
- ib_tuser  in  2  [0]=SOT (first beat of TLV), [1]=EOT (last beat of TLV)
- err_clr  in  1  clears sticky proto_err_code
- cmd_active  out  1  high between RQE SOT and CQE EOT
- rqe_entry  out  1  one-cycle pulse on the RQE SOT beat
- cqe_exit  out  1  one-cycle pulse on the CQE EOT beat
- ib_frame_cnt_stb  out  1  pulse on a DATA/DATA_UNK SOT beat
- ib_bytes_cnt_stb  out  1  pulse on each counted data payload beat
- ib_bytes_cnt_amt  out  4  popcount of ib_tstrb for that beat, 0..8
- frame_done  out  1  pulse on DATA EOT beat
- frame_bytes  out  FB_W  total payload bytes of the frame, valid with frame_done
- ib_stall  out  1  registered (ib_tvalid & !ib_tready)
- ib_starve  out  1  registered (!ib_tvalid & cmd_active)
- proto_err  out  1  one-cycle error pulse
- proto_err_code  out  2  sticky code: 0 none, 1 SOT inside TLV, 2 non-RQE outside command, 3 RQE inside command

Behaviour:
- Beat = ib_tvalid & ib_tready. Parsing and all counters advance only on beats.
- All outputs are registered, with 1-cycle latency from the beat. All outputs reset to 0 and the FSM resets to IDLE.
- FSM states: IDLE, CMD (between TLVs), IN_DATA, IN_OTHER, IN_CQE, SKIP.
  - IDLE:
    - SOT with RQE: rqe_entry=1 and cmd_active=1. Go to CMD, or to IN_OTHER if not EOT.
    - SOT with any other type: code 2. Go to SKIP, or stay in IDLE if EOT.
    - Non-SOT beat: ignored.
  - CMD:
    - SOT DATA/DATA_UNK: ib_frame_cnt_stb=1, clear the accumulator, go to IN_DATA. If the same beat is EOT, frame_done=1 with frame_bytes=0 and stay in CMD.
    - SOT CQE: go to IN_CQE. If the same beat is EOT, cqe_exit=1 and go to IDLE.
    - SOT RQE: code 3, treated as a fresh RQE; rqe_entry=1 and cmd_active stays 1.
    - Other SOT: IN_OTHER, or stay in CMD if EOT.
  - IN_DATA, non-SOT beat: ib_bytes_cnt_stb=1, amt=popcount(tstrb), accumulator += amt.
    - Accumulator saturates at all-ones.
    - On EOT: frame_done=1 and frame_bytes = the sum including this beat. Go to CMD.
    - The header (SOT) beat is never counted.
  - IN_OTHER: EOT returns to CMD.
  - IN_CQE: EOT gives cqe_exit=1, cmd_active=0, next state IDLE.
  - SKIP: ignore beats until EOT, then go to IDLE.
  - SOT seen in IN_DATA, IN_OTHER or IN_CQE: code 1. The previous TLV is abandoned with no frame_done and no cqe_exit, and the beat is reparsed as a new TLV using the CMD rules.
- proto_err pulses on every error.
- proto_err_code holds the first error code until err_clr.
  - If err_clr and a new error occur in the same cycle, the new code is loaded.
- ib_stall/ib_starve update every cycle regardless of beats.
- An asynchronous reset mid-TLV returns to IDLE with no pulses issued.

Test Plan:
- RQE(1 beat SOT+EOT), DATA 3 beats (header, tstrb FF, tstrb 0F), CQE 2 beats:
  - rqe_entry once
  - ib_frame_cnt_stb once
  - bytes stbs amt 8 then 4
  - frame_done with frame_bytes=12
  - cqe_exit once
  - cmd_active drops the cycle after the CQE EOT beat
- Same stream with tready low for 3 cycles mid-DATA:
  - ib_stall high 3 cycles
  - no extra byte strobes
  - frame_bytes still 12
- DATA SOT in IDLE:
  - proto_err pulse, code=2
  - beats dropped until EOT
  - following RQE accepted normally
- RQE, DATA header, then CQE SOT before DATA EOT:
  - code=1, no frame_done
  - cqe_exit on the CQE EOT
- RQE then second RQE: code=3, rqe_entry pulses twice, cmd_active stays 1.
- FB_W=4, DATA with three 8-byte beats: frame_bytes saturates at 15.
- err_clr pulse: code returns to 0.
